ofifo_skew_collect: RTL and testbench

Output-side collection buffer that sits directly downstream of the 8×8 MAC array. It captures the array's south-edge partial sums, which arrive column-skewed with one valid bit per column, into per-column FIFOs. It then releases them as deskewed, full-width rows to the special-function / psum-memory stage. A row becomes readable only when every column has contributed its entry for that row.

---
 rtl/ofifo_skew_collect_if.sv | 27 ++
 rtl/ofifo_skew_collect.sv | 97 +++++++++
 tb/tb_ofifo_skew_collect.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ofifo_skew_collect_if.sv
// Handshake/data bundle between the MAC array south edge, the collection buffer
// and the downstream special-function / psum-memory stage.
interface ofifo_skew_collect_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
);
    logic [psum_bw*col-1:0]       in;
    logic [col-1:0]               wr;
    logic                         rd;
    logic [psum_bw*col-1:0]       out;
    logic                         o_valid;
    logic                         o_ready;
    logic                         o_full;
    logic                         o_ovf;
    logic [$clog2(depth):0]       o_count;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_ready, o_full, o_ovf, o_count
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_ready, o_full, o_ovf, o_count
    );
endinterface

// File: rtl/ofifo_skew_collect.sv
// Per-column FIFOs that absorb column-skewed array outputs and release
// deskewed full-width rows once every column holds an entry for that row.
module ofifo_skew_collect #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                clk,
    input  logic                reset,
    ofifo_skew_collect_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [PW-1:0] DEPTH = PW'(depth);

    logic [psum_bw-1:0]     mem_q [col][depth];
    logic [PW-1:0]          wptr_q [col];
    logic [PW-1:0]          wptr_d [col];
    // Rows pop from all columns at once, so a single read pointer serves every column.
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   ovf_q, ovf_d;

    logic [PW-1:0]          occ [col];
    logic [col-1:0]         col_full;
    logic [col-1:0]         we;
    logic [PW-1:0]          min_occ;
    logic                   row_valid;

    always_comb begin
        for (int c = 0; c < col; c++) begin
            occ[c]      = wptr_q[c] - rptr_q;
            col_full[c] = (occ[c] == DEPTH);
        end
        min_occ = occ[0];
        for (int c = 1; c < col; c++) begin
            if (occ[c] < min_occ) min_occ = occ[c];
        end
        row_valid = (min_occ != '0);
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        out_d  = out_q;
        ovf_d  = ovf_q;
        we     = '0;
        // Fullness is judged on pre-edge state, so a same-cycle pop never rescues a write.
        for (int c = 0; c < col; c++) begin
            if (bus.wr[c]) begin
                if (!col_full[c]) begin
                    we[c]     = 1'b1;
                    wptr_d[c] = wptr_q[c] + ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        if (bus.rd && row_valid) begin
            rptr_d = rptr_q + ONE;
            for (int c = 0; c < col; c++) begin
                out_d[psum_bw*c +: psum_bw] = mem_q[c][rptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) wptr_q[c] <= '0;
            rptr_q <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) wptr_q[c] <= wptr_d[c];
            rptr_q <= rptr_d;
            out_q  <= out_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is not cleared by reset; dropping the pointers is enough to discard rows.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (reset && we[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= bus.in[psum_bw*c +: psum_bw];
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.o_valid = row_valid;
    assign bus.o_full  = |col_full;
    assign bus.o_ready = ~(|col_full);
    assign bus.o_ovf   = ovf_q;
    assign bus.o_count = min_occ;
endmodule

// File: tb/tb_ofifo_skew_collect.sv
// Directed bench: stimulus pushes expected rows into a queue, a negedge monitor
// pops and compares each row the DUT presents after an accepted read.
module tb_ofifo_skew_collect;
    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int DEP = 64;

    logic clk;
    logic reset;

    ofifo_skew_collect_if #(.col(COL), .psum_bw(PBW), .depth(DEP)) bus ();

    ofifo_skew_collect #(.col(COL), .psum_bw(PBW), .depth(DEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [PBW*COL-1:0] exp_q [$];
    logic pending = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PBW*COL-1:0] row_of(input int base, input int step);
        logic [PBW*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[PBW*c +: PBW] = PBW'(base + step*c);
        return r;
    endfunction

    // Monitor: out observed at negedge reflects a read accepted at the preceding posedge.
    always @(negedge clk) begin
        if (pending) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_row: got %h expected none", bus.out);
            end else begin
                check("row_out", 128'(bus.out), 128'(exp_q.pop_front()));
            end
        end
        pending = reset && bus.rd && bus.o_valid;
    end

    task automatic check_flags(input string tag, input logic v, input logic rdy,
                               input logic f, input logic ov, input int cnt);
        check({tag, "_valid"}, 128'(bus.o_valid), 128'(v));
        check({tag, "_ready"}, 128'(bus.o_ready), 128'(rdy));
        check({tag, "_full"},  128'(bus.o_full),  128'(f));
        check({tag, "_ovf"},   128'(bus.o_ovf),   128'(ov));
        check({tag, "_count"}, 128'(bus.o_count), 128'(cnt));
    endtask

    logic [PBW*COL-1:0] skew_row;
    logic [PBW*COL-1:0] row50;

    initial begin
        reset = 1'b0;
        bus.in = '0;
        bus.wr = '0;
        bus.rd = 1'b0;
        skew_row = row_of(16'h0010, 1);
        row50    = row_of(16'h0050, 1);

        // Reset state
        tick(); tick();
        reset = 1'b1;
        check("rst_out", 128'(bus.out), 128'd0);
        check_flags("rst", 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Skewed row assembly: column c written at cycle c+1
        for (int c = 0; c < COL; c++) begin
            bus.in = {COL{16'hDEAD}};
            bus.in[PBW*c +: PBW] = PBW'(16'h0010 + c);
            bus.wr = COL'(1) << c;
            tick();
            check($sformatf("skew_valid_c%0d", c), 128'(bus.o_valid), (c == COL-1) ? 128'd1 : 128'd0);
        end
        bus.wr = '0;
        check("skew_count", 128'(bus.o_count), 128'd1);
        bus.rd = 1'b1;
        exp_q.push_back(skew_row);
        tick();
        bus.rd = 1'b0;
        check("skew_out", 128'(bus.out), 128'(skew_row));
        check("skew_valid_after", 128'(bus.o_valid), 128'd0);
        check("skew_count_after", 128'(bus.o_count), 128'd0);

        // Read while empty: ignored
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("rdempty_out", 128'(bus.out), 128'(skew_row));
        check_flags("rdempty", 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Pointers still aligned: one full row goes in and comes straight back
        bus.in = row50;
        bus.wr = '1;
        tick();
        bus.wr = '0;
        check("row50_count", 128'(bus.o_count), 128'd1);
        bus.rd = 1'b1;
        exp_q.push_back(row50);
        tick();
        bus.rd = 1'b0;
        check("row50_out", 128'(bus.out), 128'(row50));

        // Fill column 3, then overflow with a simultaneous (ignored) read
        bus.wr = 8'h08;
        for (int i = 0; i < DEP; i++) begin
            bus.in[PBW*3 +: PBW] = PBW'(16'h3000 + i);
            tick();
        end
        bus.wr = '0;
        check_flags("fill", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        bus.in[PBW*3 +: PBW] = 16'hBAD0;
        bus.wr = 8'h08;
        bus.rd = 1'b1;
        tick();
        bus.wr = '0;
        bus.rd = 1'b0;
        check_flags("ovf", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("ovf_out", 128'(bus.out), 128'(row50));

        // Clear overflow and contents
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_flags("rst2", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("rst2_out", 128'(bus.out), 128'd0);

        // Streaming 200 skewed rows with continuous reads
        bus.rd = 1'b1;
        for (int t = 0; t < 200 + COL - 1; t++) begin
            bus.wr = '0;
            bus.in = '0;
            for (int c = 0; c < COL; c++) begin
                if (t - c >= 0 && t - c < 200) begin
                    bus.wr[c] = 1'b1;
                    bus.in[PBW*c +: PBW] = PBW'(t - c);
                end
            end
            if (t - (COL-1) >= 0) exp_q.push_back(row_of(t - (COL-1), 0));
            tick();
        end
        bus.wr = '0;
        for (int i = 0; i < 4; i++) tick();
        bus.rd = 1'b0;
        tick();
        check("stream_ovf", 128'(bus.o_ovf), 128'd0);
        check("stream_count", 128'(bus.o_count), 128'd0);
        check("stream_drained", 128'(exp_q.size()), 128'd0);
        check("stream_last", 128'(bus.out), 128'(row_of(199, 0)));

        // Reset mid-operation with 5 rows buffered
        bus.wr = '1;
        for (int r = 0; r < 5; r++) begin
            bus.in = row_of(16'h0100 + r, 0);
            tick();
        end
        bus.wr = '0;
        check("mid_count_before", 128'(bus.o_count), 128'd5);
        bus.in = {COL{16'hAAAA}};
        bus.wr = '1;
        bus.rd = 1'b1;
        reset  = 1'b0;
        tick();
        check_flags("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("mid_rst_out", 128'(bus.out), 128'd0);
        reset  = 1'b1;
        bus.wr = '0;
        bus.rd = 1'b0;
        tick();
        check("mid_no_retain", 128'(bus.o_count), 128'd0);
        check("mid_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
